// File: rtl/mips_single_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : MIPS_package
// Description : Shared constants, opcode/funct codes, ALU control encoding
//               and the decoded control bundle for the single-cycle MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
package MIPS_package;

    localparam int INST_MEM_DEPTH = 64;
    localparam int DATA_MEM_DEPTH = 64;
    localparam int width          = 32;
    localparam int CLK_PERIOD     = 10;

    // Primary opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    // ALU operation select
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    // Fully decoded control for one instruction
    typedef struct packed {
        logic      reg_write;
        logic      reg_dst;
        logic      alu_src;
        logic      mem_write;
        logic      mem_to_reg;
        logic      branch;
        logic      jump;
        alu_ctrl_e alu_ctrl;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mips_single_cycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_control_unit
// Description : Main decoder (opcode -> datapath controls) plus ALU decoder
//               (ALUOp/funct -> ALUControl). Unknown opcodes and unknown
//               R-type funct codes decode to a NOP (no register/memory write).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_control_unit
    import MIPS_package::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl
);

    logic      w_reg_write;
    logic      w_reg_dst;
    logic      w_alu_src;
    logic      w_mem_write;
    logic      w_mem_to_reg;
    logic      w_branch;
    logic      w_jump;
    logic [1:0] w_alu_op;
    alu_ctrl_e w_alu_ctrl;
    logic      w_funct_ok;

    // Main decoder: opcode to datapath steering and a coarse ALU class
    always_comb begin
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_branch     = 1'b0;
        w_jump       = 1'b0;
        w_alu_op     = 2'b00;
        case (i_op)
            c_OP_RTYPE: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_alu_op    = 2'b10;
            end
            c_OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            c_OP_SW: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_OP_BEQ: begin
                w_branch = 1'b1;
                w_alu_op = 2'b01;
            end
            c_OP_ADDI: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            c_OP_J: begin
                w_jump = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder: refine the ALU class with funct for R-type instructions
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_funct_ok = 1'b1;
        case (w_alu_op)
            2'b00: w_alu_ctrl = ALU_ADD;
            2'b01: w_alu_ctrl = ALU_SUB;
            default: begin
                case (i_funct)
                    c_FN_ADD: w_alu_ctrl = ALU_ADD;
                    c_FN_SUB: w_alu_ctrl = ALU_SUB;
                    c_FN_AND: w_alu_ctrl = ALU_AND;
                    c_FN_OR:  w_alu_ctrl = ALU_OR;
                    c_FN_SLT: w_alu_ctrl = ALU_SLT;
                    // Includes funct 0 (sll), so the all-zero word is a NOP
                    default:  w_funct_ok = 1'b0;
                endcase
            end
        endcase
    end

    assign o_ctrl = '{
        reg_write:  w_reg_write & w_funct_ok,
        reg_dst:    w_reg_dst,
        alu_src:    w_alu_src,
        mem_write:  w_mem_write,
        mem_to_reg: w_mem_to_reg,
        branch:     w_branch,
        jump:       w_jump,
        alu_ctrl:   w_alu_ctrl
    };

endmodule
`default_nettype wire

// File: rtl/mips_single_cycle.sv
`default_nettype none
// ============================================================================
// Module      : mips_single_cycle
// Description : Single-cycle 32-bit MIPS subset core (add/sub/and/or/slt,
//               lw/sw/beq/addi/j) with on-chip instruction and data memories.
//               One instruction retires per clock. Reset is asynchronous and
//               active-low on port rst. The instruction memory is a read-only
//               image supplied through the IMEM_INIT parameter (word i in
//               bits [i*width +: width]).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_single_cycle #(
    parameter int INST_MEM_DEPTH = MIPS_package::INST_MEM_DEPTH,
    parameter int DATA_MEM_DEPTH = MIPS_package::DATA_MEM_DEPTH,
    parameter int width          = MIPS_package::width,
    parameter logic [INST_MEM_DEPTH*width-1:0] IMEM_INIT = '0
) (
    input  logic clk,
    input  logic rst
);

    import MIPS_package::*;

    localparam int c_IMEM_AW = $clog2(INST_MEM_DEPTH);
    localparam int c_DMEM_AW = $clog2(DATA_MEM_DEPTH);

    logic [width-1:0]     r_pc;
    logic [width-1:0]     r_regs [32];
    logic [width-1:0]     r_dmem [DATA_MEM_DEPTH];
    logic [width-1:0]     w_imem [INST_MEM_DEPTH];

    logic [width-1:0]     w_instr;
    logic [c_IMEM_AW-1:0] w_imem_idx;
    logic [c_DMEM_AW-1:0] w_dmem_idx;
    logic [5:0]           w_op;
    logic [5:0]           w_funct;
    logic [4:0]           w_rs;
    logic [4:0]           w_rt;
    logic [4:0]           w_rd;
    logic [4:0]           w_write_reg;
    ctrl_t                w_ctrl;

    logic [width-1:0]     w_signimm;
    logic [width-1:0]     w_srca;
    logic [width-1:0]     w_rd2;
    logic [width-1:0]     w_srcb;
    logic [width-1:0]     ALUResult;
    logic                 w_zero;
    logic [width-1:0]     w_read_data;
    logic [width-1:0]     w_result;

    logic [width-1:0]     w_pc_plus4;
    logic [width-1:0]     w_pc_branch;
    logic [width-1:0]     w_pc_jump;
    logic [width-1:0]     w_pc_next;

    // ---------------------------------------------------------------- fetch
    for (genvar gi = 0; gi < INST_MEM_DEPTH; gi++) begin : g_imem
        assign w_imem[gi] = IMEM_INIT[gi*width +: width];
    end

    // Index wraps modulo the memory depth
    assign w_imem_idx = r_pc[c_IMEM_AW+1:2];
    assign w_instr    = w_imem[w_imem_idx];

    // --------------------------------------------------------------- decode
    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_funct = w_instr[5:0];

    mips_control_unit u_ctrl (
        .i_op    (w_op),
        .i_funct (w_funct),
        .o_ctrl  (w_ctrl)
    );

    assign w_signimm   = {{(width-16){w_instr[15]}}, w_instr[15:0]};
    assign w_write_reg = w_ctrl.reg_dst ? w_rd : w_rt;

    // $0 always reads zero regardless of array contents
    assign w_srca = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
    assign w_rd2  = (w_rt == 5'd0) ? '0 : r_regs[w_rt];

    // -------------------------------------------------------------- execute
    assign w_srcb = w_ctrl.alu_src ? w_signimm : w_rd2;

    // ALU: add/sub wrap, slt is a signed compare
    always_comb begin
        case (w_ctrl.alu_ctrl)
            ALU_ADD: ALUResult = w_srca + w_srcb;
            ALU_SUB: ALUResult = w_srca - w_srcb;
            ALU_AND: ALUResult = w_srca & w_srcb;
            ALU_OR:  ALUResult = w_srca | w_srcb;
            ALU_SLT: ALUResult = {{(width-1){1'b0}},
                                  ($signed(w_srca) < $signed(w_srcb))};
            default: ALUResult = '0;
        endcase
    end

    assign w_zero = (ALUResult == '0);

    // --------------------------------------------------------------- memory
    assign w_dmem_idx  = ALUResult[c_DMEM_AW+1:2];
    // Combinational read sees the pre-edge contents, so lw after/with sw at
    // the same address in one cycle returns the old word
    assign w_read_data = r_dmem[w_dmem_idx];

    // Data memory: cleared by reset, written on sw
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DATA_MEM_DEPTH; i++) begin
                r_dmem[i] <= '0;
            end
        end else if (w_ctrl.mem_write) begin
            r_dmem[w_dmem_idx] <= w_rd2;
        end
    end

    // ------------------------------------------------------------ writeback
    assign w_result = w_ctrl.mem_to_reg ? w_read_data : ALUResult;

    // Register file: cleared by reset, writes to $0 are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_ctrl.reg_write && (w_write_reg != 5'd0)) begin
            r_regs[w_write_reg] <= w_result;
        end
    end

    // -------------------------------------------------------------- next PC
    assign w_pc_plus4  = r_pc + width'(4);
    assign w_pc_branch = w_pc_plus4 + {w_signimm[width-3:0], 2'b00};
    assign w_pc_jump   = {w_pc_plus4[width-1:width-4], w_instr[25:0], 2'b00};

    always_comb begin
        if (w_ctrl.jump) begin
            w_pc_next = w_pc_jump;
        end else if (w_ctrl.branch && w_zero) begin
            w_pc_next = w_pc_branch;
        end else begin
            w_pc_next = w_pc_plus4;
        end
    end

    // Program counter: restarts at address 0 on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_single_cycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_single_cycle
// Description : Scoreboard bench for the single-cycle MIPS core. The stimulus
//               process pushes the expected PC/ALUResult for every cycle it
//               lets run; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_single_cycle;
    import MIPS_package::*;

    // Hand-assembled program (word index : instruction)
    localparam logic [INST_MEM_DEPTH*32-1:0] c_image = {
        {41{32'h0000_0000}},
        32'h1000FFFF,   // 22: beq $0,$0,-1   (spin)
        32'h20100003,   // 21: addi $16,$0,3
        32'h200F0055,   // 20: addi $15,$0,0x55 (skipped by j)
        32'h08000015,   // 19: j 21
        32'h200E0002,   // 18: addi $14,$0,2
        32'h200D0066,   // 17: addi $13,$0,0x66 (skipped by beq)
        32'h200D0077,   // 16: addi $13,$0,0x77 (skipped by beq)
        32'h10420002,   // 15: beq $2,$2,+2   (taken)
        32'h200C0001,   // 14: addi $12,$0,1
        32'h10430005,   // 13: beq $2,$3,+5   (not taken)
        32'h20000009,   // 12: addi $0,$0,9
        32'h8C070054,   // 11: lw  $7,84($0)
        32'hAC040054,   // 10: sw  $4,84($0)
        32'h01095825,   //  9: or  $11,$8,$9
        32'h01095024,   //  8: and $10,$8,$9
        32'h20090FF0,   //  7: addi $9,$0,0x0FF0
        32'h21087878,   //  6: addi $8,$8,0x7878
        32'h20087878,   //  5: addi $8,$0,0x7878
        32'h0043302A,   //  4: slt $6,$2,$3
        32'h00622822,   //  3: sub $5,$3,$2
        32'h00432020,   //  2: add $4,$2,$3
        32'h2003000C,   //  1: addi $3,$0,12
        32'h20020005    //  0: addi $2,$0,5
    };

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        bit          chk_alu;
    } exp_t;

    logic clk;
    logic rst;

    int   checks = 0;
    int   errors = 0;

    exp_t trace [$];
    exp_t exp_q [$];

    mips_single_cycle #(
        .IMEM_INIT (c_image)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD/2) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add_trace(input logic [31:0] pc, input logic [31:0] alu, input bit chk_alu);
        exp_t e;
        e.pc      = pc;
        e.alu     = alu;
        e.chk_alu = chk_alu;
        trace.push_back(e);
    endtask

    // Let n cycles execute, queuing what each cycle should present
    task automatic run_cycles(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(trace[first + i]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_final();
        chk("r0",  dut.r_regs[0],  32'h0);
        chk("r2",  dut.r_regs[2],  32'h5);
        chk("r3",  dut.r_regs[3],  32'hC);
        chk("r4",  dut.r_regs[4],  32'h11);
        chk("r5",  dut.r_regs[5],  32'h7);
        chk("r6",  dut.r_regs[6],  32'h1);
        chk("r7",  dut.r_regs[7],  32'h11);
        chk("r8",  dut.r_regs[8],  32'hF0F0);
        chk("r9",  dut.r_regs[9],  32'h0FF0);
        chk("r10_and", dut.r_regs[10], 32'h00F0);
        chk("r11_or",  dut.r_regs[11], 32'hFFF0);
        chk("r12", dut.r_regs[12], 32'h1);
        chk("r13_skipped", dut.r_regs[13], 32'h0);
        chk("r14", dut.r_regs[14], 32'h2);
        chk("r15_skipped", dut.r_regs[15], 32'h0);
        chk("r16", dut.r_regs[16], 32'h3);
        chk("dmem21", dut.r_dmem[21], 32'h11);
        chk("pc_spin", dut.r_pc, 32'd88);
    endtask

    // Monitor: one retiring instruction per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", dut.r_pc, e.pc);
            if (e.chk_alu) begin
                chk("alu", dut.ALUResult, e.alu);
            end
        end
    end

    initial begin
        #(100000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected per-cycle PC and ALUResult
        add_trace(32'd0,  32'h5,        1);
        add_trace(32'd4,  32'hC,        1);
        add_trace(32'd8,  32'h11,       1);
        add_trace(32'd12, 32'h7,        1);
        add_trace(32'd16, 32'h1,        1);
        add_trace(32'd20, 32'h7878,     1);
        add_trace(32'd24, 32'hF0F0,     1);
        add_trace(32'd28, 32'h0FF0,     1);
        add_trace(32'd32, 32'h00F0,     1);
        add_trace(32'd36, 32'hFFF0,     1);
        add_trace(32'd40, 32'h54,       1);
        add_trace(32'd44, 32'h54,       1);
        add_trace(32'd48, 32'h9,        1);
        add_trace(32'd52, 32'hFFFFFFF9, 1);
        add_trace(32'd56, 32'h1,        1);
        add_trace(32'd60, 32'h0,        1);
        add_trace(32'd72, 32'h2,        1);
        add_trace(32'd76, 32'h0,        0);
        add_trace(32'd84, 32'h3,        1);
        for (int i = 0; i < 26; i++) begin
            add_trace(32'd88, 32'h0, 1);
        end

        // Reset held across one edge
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_pc", dut.r_pc, 32'h0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("reset_r%0d", i), dut.r_regs[i], 32'h0);
        end
        chk("reset_dmem21", dut.r_dmem[21], 32'h0);

        // Full program, ending in 26 spin cycles
        rst = 1'b1;
        run_cycles(0, trace.size());
        check_final();

        // Restart, then assert reset asynchronously after cycle 10
        #2 rst = 1'b0;
        #1;
        chk("rst2_pc", dut.r_pc, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        run_cycles(0, 10);
        chk("mid_r11_before", dut.r_regs[11], 32'hFFF0);
        #2 rst = 1'b0;
        #1;
        chk("mid_pc", dut.r_pc, 32'h0);
        chk("mid_r2", dut.r_regs[2], 32'h0);
        chk("mid_r4", dut.r_regs[4], 32'h0);
        chk("mid_r11", dut.r_regs[11], 32'h0);
        @(posedge clk);
        #1;
        chk("mid_pc_held", dut.r_pc, 32'h0);
        rst = 1'b1;

        // Rerun must reproduce the identical trace and final state
        run_cycles(0, trace.size());
        check_final();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
